// File: rtl/bsg_axi_pkg.sv
// AXI response encodings shared by AXI-facing blocks.
// Types only; no logic.
package bsg_axi_pkg;

    typedef enum logic [1:0] {
        e_axi_resp_okay   = 2'b00,
        e_axi_resp_exokay = 2'b01,
        e_axi_resp_slverr = 2'b10,
        e_axi_resp_decerr = 2'b11
    } axi_resp_e;

endpackage

// File: rtl/bsg_axil_client_pkg.sv
// Shared types for the AXI-Lite client: tracker entries, arbiter and grant state.
// Types only; no logic.
package bsg_axil_client_pkg;

    import bsg_axi_pkg::*;

    typedef struct packed {
        logic w;
        logic err;
    } tracker_entry_s;

    localparam axi_resp_e client_resp_okay   = e_axi_resp_okay;
    localparam axi_resp_e client_resp_decerr = e_axi_resp_decerr;

    typedef enum logic {
        e_prio_read,
        e_prio_write
    } arb_prio_e;

    typedef enum logic {
        e_grant_free,
        e_grant_held
    } grant_state_e;

endpackage

// File: rtl/bsg_axil_client_fifo.sv
// Small two-port circular FIFO with valid/ready push and yumi pop.
// Latency: push visible at the head one cycle later. Backpressure: ready_o low when full.
module bsg_axil_client_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rptr_r, wptr_r;
    logic [cnt_w-1:0]   cnt_r;
    logic               push, pop;

    assign ready_o = (cnt_r != cnt_w'(els_p));
    assign v_o     = (cnt_r != '0);
    assign data_o  = mem[rptr_r];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rptr_r <= '0;
            wptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (push) wptr_r <= (wptr_r == ptr_w'(els_p - 1)) ? '0 : wptr_r + ptr_w'(1);
            if (pop)  rptr_r <= (rptr_r == ptr_w'(els_p - 1)) ? '0 : rptr_r + ptr_w'(1);
            if (push && !pop)      cnt_r <= cnt_r + cnt_w'(1);
            else if (!push && pop) cnt_r <= cnt_r - cnt_w'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_axil_client_return_tracker.sv
// In-order tracker of issued requests; routes downstream responses to B or R. Macro: BSG_AXIL_FIFO_CLIENT_DECERR_EN.
// Latency: v_i to b/rvalid combinational. Backpressure: ready_and_o follows bready/rready of the head's channel.
module bsg_axil_client_return_tracker
    import bsg_axil_client_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int els_p        = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    push_v_i,
    input  tracker_entry_s          push_entry_i,
    output logic                    ready_o,
    input  logic [data_width_p-1:0] data_i,
    input  logic                    v_i,
    output logic                    ready_and_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    output logic [data_width_p-1:0] rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rvalid_o,
    input  logic                    rready_i
);

    tracker_entry_s head;
    logic           head_v, err_head, resp_v, pop;

    bsg_axil_client_fifo #(.width_p($bits(tracker_entry_s)), .els_p(els_p)) track_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .data_i   (push_entry_i),
        .v_i      (push_v_i),
        .ready_o  (ready_o),
        .data_o   (head),
        .v_o      (head_v),
        .yumi_i   (pop)
    );

`ifdef BSG_AXIL_FIFO_CLIENT_DECERR_EN
    assign err_head = head_v & head.err;
`else
    logic unused_err;
    assign unused_err = head.err;
    assign err_head   = 1'b0;
`endif

    // A locally rejected request answers itself without waiting for the device.
    assign resp_v      = head_v & (err_head | v_i);
    assign bvalid_o    = resp_v & head.w;
    assign rvalid_o    = resp_v & ~head.w;
    assign ready_and_o = head_v & ~err_head & (head.w ? bready_i : rready_i);
    assign pop         = (bvalid_o & bready_i) | (rvalid_o & rready_i);
    assign bresp_o     = err_head ? client_resp_decerr : client_resp_okay;
    assign rresp_o     = err_head ? client_resp_decerr : client_resp_okay;
    assign rdata_o     = err_head ? '0 : data_i;

    orphan_response: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(v_i && !head_v));

endmodule

// File: rtl/bsg_axil_fifo_client_multi.sv
// AXI-Lite subordinate to a single request stream, round-robin R/W, multiple outstanding. Macro: BSG_AXIL_FIFO_CLIENT_DECERR_EN.
// Latency: AXI handshake to v_o one cycle; v_i to b/rvalid combinational. Backpressure: AXI ready = FIFO not full; issue stalls on a full tracker.
module bsg_axil_fifo_client_multi
    import bsg_axil_client_pkg::*;
#(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    parameter int fifo_els_p        = 2,
    parameter int outstanding_els_p = 4,
    parameter logic [axil_addr_width_p-1:0] legal_addr_lo_p = '0,
    parameter logic [axil_addr_width_p-1:0] legal_addr_hi_p = '1
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    output logic [axil_data_width_p-1:0]     data_o,
    output logic [axil_addr_width_p-1:0]     addr_o,
    output logic                             v_o,
    output logic                             w_o,
    output logic [axil_data_width_p/8-1:0]   wmask_o,
    input  logic                             ready_and_i,
    input  logic [axil_data_width_p-1:0]     data_i,
    input  logic                             v_i,
    output logic                             ready_and_o,
    input  logic [axil_addr_width_p-1:0]     s_axil_awaddr,
    input  logic [2:0]                       s_axil_awprot,
    input  logic                             s_axil_awvalid,
    output logic                             s_axil_awready,
    input  logic [axil_data_width_p-1:0]     s_axil_wdata,
    input  logic [axil_data_width_p/8-1:0]   s_axil_wstrb,
    input  logic                             s_axil_wvalid,
    output logic                             s_axil_wready,
    output logic [1:0]                       s_axil_bresp,
    output logic                             s_axil_bvalid,
    input  logic                             s_axil_bready,
    input  logic [axil_addr_width_p-1:0]     s_axil_araddr,
    input  logic [2:0]                       s_axil_arprot,
    input  logic                             s_axil_arvalid,
    output logic                             s_axil_arready,
    output logic [axil_data_width_p-1:0]     s_axil_rdata,
    output logic [1:0]                       s_axil_rresp,
    output logic                             s_axil_rvalid,
    input  logic                             s_axil_rready
);

    localparam int mask_w = axil_data_width_p / 8;
    localparam logic [axil_addr_width_p-1:0] align_mask = ~(axil_addr_width_p'(mask_w - 1));

    logic [axil_addr_width_p-1:0] ar_addr, aw_addr, issue_addr;
    logic [axil_data_width_p-1:0] w_data;
    logic [mask_w-1:0]            w_strb;
    logic ar_v, aw_v, w_v, ar_rdy, aw_rdy, w_rdy;
    logic ar_yumi, wr_yumi;
    logic rd_cand, wr_cand, sel_w, issue_v, req_err, hs;
    logic trk_ready, trk_ready_and, trk_bvalid, trk_rvalid;
    tracker_entry_s trk_entry;

    grant_state_e grant_r, grant_n;
    arb_prio_e    prio_r, prio_n;
    logic         lock_w_r, lock_w_n;

    bsg_axil_client_fifo #(.width_p(axil_addr_width_p), .els_p(fifo_els_p)) ar_fifo (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .data_i(s_axil_araddr), .v_i(s_axil_arvalid), .ready_o(ar_rdy),
        .data_o(ar_addr), .v_o(ar_v), .yumi_i(ar_yumi)
    );

    bsg_axil_client_fifo #(.width_p(axil_addr_width_p), .els_p(fifo_els_p)) aw_fifo (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .data_i(s_axil_awaddr), .v_i(s_axil_awvalid), .ready_o(aw_rdy),
        .data_o(aw_addr), .v_o(aw_v), .yumi_i(wr_yumi)
    );

    bsg_axil_client_fifo #(.width_p(axil_data_width_p + mask_w), .els_p(fifo_els_p)) w_fifo (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .data_i({s_axil_wstrb, s_axil_wdata}), .v_i(s_axil_wvalid), .ready_o(w_rdy),
        .data_o({w_strb, w_data}), .v_o(w_v), .yumi_i(wr_yumi)
    );

    assign s_axil_arready = ar_rdy & reset_n_i;
    assign s_axil_awready = aw_rdy & reset_n_i;
    assign s_axil_wready  = w_rdy & reset_n_i;

    assign rd_cand = ar_v;
    assign wr_cand = aw_v & w_v;

    always_comb begin
        sel_w = wr_cand & (~rd_cand | (prio_r == e_prio_write));
        if (grant_r == e_grant_held) sel_w = lock_w_r;
        issue_addr = sel_w ? aw_addr : (ar_addr & align_mask);
        issue_v    = (sel_w ? wr_cand : rd_cand) & trk_ready & reset_n_i;
    end

`ifdef BSG_AXIL_FIFO_CLIENT_DECERR_EN
    logic [5:0] unused_prot;
    assign unused_prot = {s_axil_awprot, s_axil_arprot};
    assign req_err = (issue_addr < legal_addr_lo_p) | (issue_addr > legal_addr_hi_p);
`else
    logic unused_cfg;
    assign unused_cfg = ^{s_axil_awprot, s_axil_arprot, legal_addr_lo_p, legal_addr_hi_p};
    assign req_err    = 1'b0;
`endif

    // Rejected requests complete on their own turn without touching the device.
    assign v_o     = issue_v & ~req_err;
    assign hs      = issue_v & (req_err | ready_and_i);
    assign ar_yumi = hs & ~sel_w;
    assign wr_yumi = hs & sel_w;

    assign addr_o  = issue_addr;
    assign w_o     = sel_w;
    assign data_o  = sel_w ? w_data : '0;
    assign wmask_o = sel_w ? w_strb : '0;

    always_comb begin
        trk_entry = '{w: sel_w, err: req_err};
        grant_n   = grant_r;
        prio_n    = prio_r;
        lock_w_n  = lock_w_r;
        if (hs) begin
            grant_n = e_grant_free;
            prio_n  = sel_w ? e_prio_read : e_prio_write;
        end else if (v_o) begin
            grant_n  = e_grant_held;
            lock_w_n = sel_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            grant_r  <= e_grant_free;
            prio_r   <= e_prio_read;
            lock_w_r <= 1'b0;
        end else begin
            grant_r  <= grant_n;
            prio_r   <= prio_n;
            lock_w_r <= lock_w_n;
        end
    end

    bsg_axil_client_return_tracker #(
        .data_width_p(axil_data_width_p),
        .els_p       (outstanding_els_p)
    ) tracker (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .push_v_i    (hs),
        .push_entry_i(trk_entry),
        .ready_o     (trk_ready),
        .data_i      (data_i),
        .v_i         (v_i),
        .ready_and_o (trk_ready_and),
        .bresp_o     (s_axil_bresp),
        .bvalid_o    (trk_bvalid),
        .bready_i    (s_axil_bready),
        .rdata_o     (s_axil_rdata),
        .rresp_o     (s_axil_rresp),
        .rvalid_o    (trk_rvalid),
        .rready_i    (s_axil_rready)
    );

    assign ready_and_o   = trk_ready_and & reset_n_i;
    assign s_axil_bvalid = trk_bvalid & reset_n_i;
    assign s_axil_rvalid = trk_rvalid & reset_n_i;

endmodule
